// File: rtl/xvga_timing_gen.sv
// XVGA (1024x768 @ 60 Hz) raster timing generator.
// Produces registered pixel/line counters, active-low syncs, blank, delayed
// copies of sync/blank for pipelined renderers, and line/frame start strobes.
// All state advances only on edges where en is high.

module xvga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter int unsigned DELAY    = 4
) (
  input  logic        vclock,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        hsync_d,
  output logic        vsync_d,
  output logic        blank_d,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        bl_q, bl_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;

  // Next-state counters: hcount wraps at the end of a line, vcount steps on that wrap.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = 11'd0;
        if (vcount_q == V_LAST) begin
          vcount_d = 10'd0;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end
  end

  // Decode sync/blank/strobes from the next counter values so the registered
  // versions change on the same edge as the counters themselves.
  always_comb begin
    hs_d = ~((hcount_d >= HS_START) && (hcount_d < HS_END));
    vs_d = ~((vcount_d >= VS_START) && (vcount_d < VS_END));
    bl_d = (hcount_d >= H_VIS) || (vcount_d >= V_VIS);
    // Strobes are forced low on stalled edges so they never stretch.
    ls_d = en && (hcount_d == 11'd0);
    fs_d = en && (hcount_d == 11'd0) && (vcount_d == 10'd0);
  end

  // Counter and decoded-output registers; reset abandons the current frame.
  always_ff @(posedge vclock or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q <= 11'd0;
      vcount_q <= 10'd0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      bl_q     <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      bl_q     <= bl_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign blank       = bl_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

  // Delay line for renderers: stage 0 captures the current registered
  // sync/blank, so the last stage lags by exactly DELAY enabled edges.
  if (DELAY == 0) begin : g_no_delay
    assign hsync_d = hs_q;
    assign vsync_d = vs_q;
    assign blank_d = bl_q;
  end else begin : g_delay
    logic [DELAY-1:0] hs_pipe_q;
    logic [DELAY-1:0] vs_pipe_q;
    logic [DELAY-1:0] bl_pipe_q;

    // Shift on enabled edges only; reset fills with idle (sync high, blanked).
    always_ff @(posedge vclock or negedge rst_n) begin
      if (!rst_n) begin
        hs_pipe_q <= '1;
        vs_pipe_q <= '1;
        bl_pipe_q <= '1;
      end else if (en) begin
        hs_pipe_q[0] <= hs_q;
        vs_pipe_q[0] <= vs_q;
        bl_pipe_q[0] <= bl_q;
        for (int i = 1; i < int'(DELAY); i++) begin
          hs_pipe_q[i] <= hs_pipe_q[i-1];
          vs_pipe_q[i] <= vs_pipe_q[i-1];
          bl_pipe_q[i] <= bl_pipe_q[i-1];
        end
      end
    end

    assign hsync_d = hs_pipe_q[DELAY-1];
    assign vsync_d = vs_pipe_q[DELAY-1];
    assign blank_d = bl_pipe_q[DELAY-1];
  end

endmodule

// File: tb/tb_xvga_timing_gen.sv
// Directed bench: a default-size instance for horizontal timing and DELAY=4,
// plus two scaled-down instances (DELAY=2 and DELAY=0) for whole-frame,
// stall and mid-frame reset scenarios.
// Small timing: H 16+2+4+6=28 (hsync low 18..21), V 10+1+2+3=16 (vsync low 11..12).

module tb_xvga_timing_gen;

  logic vclock = 1'b0;
  logic rst_n  = 1'b0;
  logic en     = 1'b0;

  always #5 vclock = ~vclock;

  // Default-parameter instance.
  logic [10:0] b_h;
  logic [9:0]  b_v;
  logic b_hs, b_vs, b_bl, b_hsd, b_vsd, b_bld, b_ls, b_fs;

  xvga_timing_gen dut (
    .vclock(vclock), .rst_n(rst_n), .en(en),
    .hcount(b_h), .vcount(b_v), .hsync(b_hs), .vsync(b_vs), .blank(b_bl),
    .hsync_d(b_hsd), .vsync_d(b_vsd), .blank_d(b_bld),
    .line_start(b_ls), .frame_start(b_fs)
  );

  // Scaled-down instance, DELAY=2.
  logic [10:0] s_h;
  logic [9:0]  s_v;
  logic s_hs, s_vs, s_bl, s_hsd, s_vsd, s_bld, s_ls, s_fs;

  xvga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(6),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3), .DELAY(2)
  ) dut_s (
    .vclock(vclock), .rst_n(rst_n), .en(en),
    .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs), .blank(s_bl),
    .hsync_d(s_hsd), .vsync_d(s_vsd), .blank_d(s_bld),
    .line_start(s_ls), .frame_start(s_fs)
  );

  // Scaled-down instance, DELAY=0.
  logic [10:0] z_h;
  logic [9:0]  z_v;
  logic z_hs, z_vs, z_bl, z_hsd, z_vsd, z_bld, z_ls, z_fs;

  xvga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(6),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3), .DELAY(0)
  ) dut_z (
    .vclock(vclock), .rst_n(rst_n), .en(en),
    .hcount(z_h), .vcount(z_v), .hsync(z_hs), .vsync(z_vs), .blank(z_bl),
    .hsync_d(z_hsd), .vsync_d(z_vsd), .blank_d(z_bld),
    .line_start(z_ls), .frame_start(z_fs)
  );

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge vclock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) tick();
    total++; if (b_h !== 11'd0) begin bad++; $display("FAIL reset_hcount: got %0d want 0", b_h); end
    total++; if (b_v !== 10'd0) begin bad++; $display("FAIL reset_vcount: got %0d want 0", b_v); end
    total++; if (b_hs !== 1'b1) begin bad++; $display("FAIL reset_hsync: got %0d want 1", b_hs); end
    total++; if (b_vs !== 1'b1) begin bad++; $display("FAIL reset_vsync: got %0d want 1", b_vs); end
    total++; if (b_bl !== 1'b0) begin bad++; $display("FAIL reset_blank: got %0d want 0", b_bl); end
    total++; if ({b_hsd, b_vsd, b_bld} !== 3'b111) begin
      bad++; $display("FAIL reset_delayed: got %b want 111", {b_hsd, b_vsd, b_bld});
    end
    total++; if ({s_hsd, s_vsd, s_bld} !== 3'b111) begin
      bad++; $display("FAIL reset_delayed_small: got %b want 111", {s_hsd, s_vsd, s_bld});
    end
    total++; if ({b_ls, b_fs, s_ls, s_fs} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes: got %b want 0000", {b_ls, b_fs, s_ls, s_fs});
    end
    rst_n = 1'b1;
  endtask

  // One full line of the default instance right after reset release.
  task automatic test_hsweep();
    int cnt_err = 0, ls_err = 0, hs_err = 0, bl_err = 0, fs_cnt = 0;
    logic hs1047 = 1'bx, hs1048 = 1'bx;
    logic hsd1051 = 1'bx, hsd1052 = 1'bx, hsd1187 = 1'bx, hsd1188 = 1'bx;
    for (int i = 1; i <= 1344; i++) begin
      int eh, ev;
      tick();
      eh = i % 1344;
      ev = (i == 1344) ? 1 : 0;
      if (b_h !== 11'(eh) || b_v !== 10'(ev)) cnt_err++;
      if (b_ls !== (eh == 0)) ls_err++;
      if (b_hs !== !(eh >= 1048 && eh < 1184)) hs_err++;
      if (b_bl !== (eh >= 1024)) bl_err++;
      if (b_fs === 1'b1) fs_cnt++;
      if (i == 1047) hs1047 = b_hs;
      if (i == 1048) hs1048 = b_hs;
      if (i == 1051) hsd1051 = b_hsd;
      if (i == 1052) hsd1052 = b_hsd;
      if (i == 1187) hsd1187 = b_hsd;
      if (i == 1188) hsd1188 = b_hsd;
    end
    total++; if (cnt_err != 0) begin bad++; $display("FAIL hsweep_counters: got %0d bad cycles want 0", cnt_err); end
    total++; if (ls_err != 0) begin bad++; $display("FAIL hsweep_line_start: got %0d bad cycles want 0", ls_err); end
    total++; if (hs_err != 0) begin bad++; $display("FAIL hsweep_hsync: got %0d bad cycles want 0", hs_err); end
    total++; if (bl_err != 0) begin bad++; $display("FAIL hsweep_blank: got %0d bad cycles want 0", bl_err); end
    total++; if (fs_cnt != 0) begin bad++; $display("FAIL hsweep_frame_start: got %0d pulses want 0", fs_cnt); end
    total++; if ({hs1047, hs1048} !== 2'b10) begin
      bad++; $display("FAIL hsync_edge_1048: got %b want 10", {hs1047, hs1048});
    end
    total++; if ({hsd1051, hsd1052} !== 2'b10) begin
      bad++; $display("FAIL hsync_d_fall_1052: got %b want 10", {hsd1051, hsd1052});
    end
    total++; if ({hsd1187, hsd1188} !== 2'b01) begin
      bad++; $display("FAIL hsync_d_rise_1188: got %b want 01", {hsd1187, hsd1188});
    end
  endtask

  // One whole frame of the small instances, starting at h=0,v=0.
  task automatic test_frame();
    int fs_cnt = 0, ls_cnt = 0, vs_low = 0, hs_low = 0, vis = 0, fs_alone = 0;
    int d_err = 0, z_err = 0;
    logic [2:0] p1, p2;
    total++; if (s_h !== 11'd0 || s_v !== 10'd0) begin
      bad++; $display("FAIL frame_start_pos: got h=%0d v=%0d want h=0 v=0", s_h, s_v);
    end
    p1 = {s_hs, s_vs, s_bl};
    p2 = 3'bxxx;
    for (int k = 1; k <= 448; k++) begin
      tick();
      if (s_fs === 1'b1) fs_cnt++;
      if (s_ls === 1'b1) ls_cnt++;
      if (s_fs === 1'b1 && s_ls !== 1'b1) fs_alone++;
      if (s_vs === 1'b0) vs_low++;
      if (s_hs === 1'b0) hs_low++;
      if (s_bl === 1'b0) vis++;
      if (k >= 2 && {s_hsd, s_vsd, s_bld} !== p2) d_err++;
      if ({z_hsd, z_vsd, z_bld} !== {z_hs, z_vs, z_bl}) z_err++;
      p2 = p1;
      p1 = {s_hs, s_vs, s_bl};
    end
    total++; if (fs_cnt != 1) begin bad++; $display("FAIL frame_fs_count: got %0d want 1", fs_cnt); end
    total++; if (ls_cnt != 16) begin bad++; $display("FAIL frame_ls_count: got %0d want 16", ls_cnt); end
    total++; if (fs_alone != 0) begin bad++; $display("FAIL frame_fs_without_ls: got %0d want 0", fs_alone); end
    total++; if (vs_low != 56) begin bad++; $display("FAIL frame_vsync_low: got %0d want 56", vs_low); end
    total++; if (hs_low != 64) begin bad++; $display("FAIL frame_hsync_low: got %0d want 64", hs_low); end
    total++; if (vis != 160) begin bad++; $display("FAIL frame_visible: got %0d want 160", vis); end
    total++; if (d_err != 0) begin bad++; $display("FAIL frame_delay2: got %0d bad cycles want 0", d_err); end
    total++; if (z_err != 0) begin bad++; $display("FAIL frame_delay0: got %0d bad cycles want 0", z_err); end
    total++; if (s_h !== 11'd0 || s_v !== 10'd0) begin
      bad++; $display("FAIL frame_end_pos: got h=%0d v=%0d want h=0 v=0", s_h, s_v);
    end
  endtask

  // 1-on/2-off enable pattern across hsync/blank edges and a line wrap.
  task automatic test_stall();
    int adv_err = 0, hold_err = 0, strobe_err = 0, d_err = 0, ls_seen = 0, n = 0;
    logic [1:0] p1, p2, dsave;
    logic hs_save;
    repeat (14) tick();
    total++; if (s_h !== 11'd14 || s_v !== 10'd0) begin
      bad++; $display("FAIL stall_start_pos: got h=%0d v=%0d want h=14 v=0", s_h, s_v);
    end
    p1 = {s_hs, s_bl};
    p2 = 2'bxx;
    for (int p = 1; p <= 15; p++) begin
      int eh;
      en = 1'b1;
      tick();
      n++;
      eh = (14 + p) % 28;
      if (s_h !== 11'(eh)) adv_err++;
      if (s_ls === 1'b1) ls_seen++;
      if (s_ls !== (eh == 0)) strobe_err++;
      if (n >= 2 && {s_hsd, s_bld} !== p2) d_err++;
      p2 = p1;
      p1 = {s_hs, s_bl};
      dsave = {s_hsd, s_bld};
      hs_save = s_hs;
      en = 1'b0;
      repeat (2) begin
        tick();
        if (s_h !== 11'(eh) || s_hs !== hs_save || {s_hsd, s_bld} !== dsave) hold_err++;
        if (s_ls !== 1'b0 || s_fs !== 1'b0) strobe_err++;
      end
    end
    en = 1'b1;
    total++; if (adv_err != 0) begin bad++; $display("FAIL stall_advance: got %0d bad steps want 0", adv_err); end
    total++; if (hold_err != 0) begin bad++; $display("FAIL stall_hold: got %0d bad cycles want 0", hold_err); end
    total++; if (strobe_err != 0) begin bad++; $display("FAIL stall_strobe: got %0d bad cycles want 0", strobe_err); end
    total++; if (ls_seen != 1) begin bad++; $display("FAIL stall_ls_count: got %0d want 1", ls_seen); end
    total++; if (d_err != 0) begin bad++; $display("FAIL stall_delay_align: got %0d bad steps want 0", d_err); end
    total++; if (s_h !== 11'd1 || s_v !== 10'd1) begin
      bad++; $display("FAIL stall_end_pos: got h=%0d v=%0d want h=1 v=1", s_h, s_v);
    end
  endtask

  // Asynchronous reset in the middle of a frame, then restart.
  task automatic test_midreset();
    repeat (131) tick();
    total++; if (s_h !== 11'd20 || s_v !== 10'd5 || s_hs !== 1'b0 || s_bl !== 1'b1) begin
      bad++; $display("FAIL midreset_pre: got h=%0d v=%0d hs=%0d bl=%0d want h=20 v=5 hs=0 bl=1",
                      s_h, s_v, s_hs, s_bl);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (s_h !== 11'd0 || s_v !== 10'd0 || b_h !== 11'd0 || b_v !== 10'd0) begin
      bad++; $display("FAIL midreset_async_counters: got s=%0d/%0d b=%0d/%0d want 0/0 0/0",
                      s_h, s_v, b_h, b_v);
    end
    total++; if ({s_hs, s_vs, s_bl} !== 3'b110) begin
      bad++; $display("FAIL midreset_async_sync: got %b want 110", {s_hs, s_vs, s_bl});
    end
    total++; if ({s_hsd, s_vsd, s_bld, s_ls, s_fs} !== 5'b11100) begin
      bad++; $display("FAIL midreset_async_delayed: got %b want 11100", {s_hsd, s_vsd, s_bld, s_ls, s_fs});
    end
    repeat (2) tick();
    total++; if (s_h !== 11'd0 || b_h !== 11'd0) begin
      bad++; $display("FAIL midreset_held: got s=%0d b=%0d want 0 0", s_h, b_h);
    end
    en = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    total++; if (s_h !== 11'd0 || b_h !== 11'd0) begin
      bad++; $display("FAIL midreset_stalled_release: got s=%0d b=%0d want 0 0", s_h, b_h);
    end
    en = 1'b1;
    tick();
    total++; if (s_h !== 11'd1 || s_v !== 10'd0 || b_h !== 11'd1 || b_v !== 10'd0) begin
      bad++; $display("FAIL midreset_restart: got s=%0d/%0d b=%0d/%0d want 1/0 1/0",
                      s_h, s_v, b_h, b_v);
    end
    total++; if ({s_ls, s_fs} !== 2'b00) begin
      bad++; $display("FAIL midreset_restart_strobes: got %b want 00", {s_ls, s_fs});
    end
  endtask

  initial begin
    test_reset();
    test_hsweep();
    test_frame();
    test_stall();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
